// File: rtl/irq_gen_pkg.sv
// irq_gen_pkg: shared constants and FSM state encoding for the MSI interrupt generator.
//   IRQ_CNT_W        width of the granted-interrupt counter
//   IRQ_GAP_DEFAULT  moderation gap the host register block loads after reset
//   irq_state_t      IDLE / REQ / GAP encoding
package irq_gen_pkg;

  localparam int unsigned IRQ_CNT_W         = 32;
  localparam int unsigned IRQ_GAP_W_DEFAULT = 16;
  localparam logic [15:0] IRQ_GAP_DEFAULT   = 16'd1000;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_GAP  = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_gen_if.sv
// irq_gen_if: groups the collapser handshake, host controls and the endpoint
// configuration-interrupt port seen by irq_gen.
//   master: collapser/host/endpoint side (drives data_rdy, irq_en, irq_gap,
//           cfg_interrupt_msienable, cfg_interrupt_rdy_n)
//   slave : irq_gen side (drives data_rdy_ack, cfg_interrupt_n, irq_cnt)
interface irq_gen_if
  import irq_gen_pkg::*;
#(
  parameter int unsigned GAP_W = IRQ_GAP_W_DEFAULT
);

  logic                 data_rdy;
  logic                 data_rdy_ack;
  logic                 irq_en;
  logic [GAP_W-1:0]     irq_gap;
  logic                 cfg_interrupt_msienable;
  logic                 cfg_interrupt_n;
  logic                 cfg_interrupt_rdy_n;
  logic [IRQ_CNT_W-1:0] irq_cnt;

  modport master (
    output data_rdy,
    output irq_en,
    output irq_gap,
    output cfg_interrupt_msienable,
    output cfg_interrupt_rdy_n,
    input  data_rdy_ack,
    input  cfg_interrupt_n,
    input  irq_cnt
  );

  modport slave (
    input  data_rdy,
    input  irq_en,
    input  irq_gap,
    input  cfg_interrupt_msienable,
    input  cfg_interrupt_rdy_n,
    output data_rdy_ack,
    output cfg_interrupt_n,
    output irq_cnt
  );

endinterface

// File: rtl/irq_gen_gap_timer.sv
// irq_gap_timer: moderation gap down-counter.
//   clk, rst  clock and synchronous active-high reset
//   load      load load_val (takes priority over dec)
//   dec       decrement by one, saturating at zero
//   load_val  gap value in clk cycles
//   zero_c    combinational: counter is zero
module irq_gap_timer
  import irq_gen_pkg::*;
#(
  parameter int unsigned GAP_W = IRQ_GAP_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [GAP_W-1:0] load_val,
  output logic             zero_c
);

  logic [GAP_W-1:0] cnt;

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - GAP_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/irq_gen.sv
// irq_gen: acknowledges collapser event pulses, merges pending events and
// issues rate-limited MSI requests to the PCIe endpoint.
//   clk, rst                      clock and synchronous active-high reset
//   bus.data_rdy / data_rdy_ack   event pulse in, ack (data_rdy delayed one cycle) out
//   bus.irq_en                    host interrupt enable (0 = polling mode)
//   bus.irq_gap                   minimum cycles between interrupts, sampled on grant
//   bus.cfg_interrupt_msienable   MSI enabled by the root complex
//   bus.cfg_interrupt_n           request to endpoint, active-low, low exactly in REQ
//   bus.cfg_interrupt_rdy_n       grant from endpoint, active-low
//   bus.irq_cnt                   granted interrupt count, wraps
module irq_gen
  import irq_gen_pkg::*;
#(
  parameter int unsigned GAP_W = IRQ_GAP_W_DEFAULT
) (
  input logic        clk,
  input logic        rst,
  irq_gen_if.slave   bus
);

  irq_state_t           state;
  irq_state_t           state_nxt;
  logic                 pend;
  logic                 pend_nxt;
  logic                 ack_q;
  logic                 req_n_q;
  logic [IRQ_CNT_W-1:0] cnt_q;
  logic [IRQ_CNT_W-1:0] cnt_nxt;
  logic                 tmr_load_c;
  logic                 tmr_dec_c;
  logic                 tmr_zero_c;

  irq_gap_timer #(
    .GAP_W (GAP_W)
  ) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_c),
    .dec      (tmr_dec_c),
    .load_val (GAP_W'(bus.irq_gap)),
    .zero_c   (tmr_zero_c)
  );

  // Ack path: independent of the FSM, every pulse is echoed one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= bus.data_rdy;
    end
  end

  // State, pending flag, counter and registered request output
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IRQ_IDLE;
      pend    <= 1'b0;
      cnt_q   <= '0;
      req_n_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      pend    <= pend_nxt;
      cnt_q   <= cnt_nxt;
      req_n_q <= (state_nxt != IRQ_REQ);
    end
  end

  // Next-state logic; a data_rdy coincident with the grant keeps pend set
  always_comb begin
    state_nxt  = state;
    pend_nxt   = pend | bus.data_rdy;
    cnt_nxt    = cnt_q;
    tmr_load_c = 1'b0;
    tmr_dec_c  = 1'b0;
    case (state)
      IRQ_IDLE: begin
        if (pend && bus.irq_en && bus.cfg_interrupt_msienable) begin
          state_nxt = IRQ_REQ;
        end
      end
      IRQ_REQ: begin
        // Held regardless of irq_en/msienable until the endpoint grants
        if (!bus.cfg_interrupt_rdy_n) begin
          pend_nxt   = bus.data_rdy;
          cnt_nxt    = cnt_q + IRQ_CNT_W'(1);
          tmr_load_c = 1'b1;
          state_nxt  = IRQ_GAP;
        end
      end
      IRQ_GAP: begin
        if (tmr_zero_c) begin
          state_nxt = IRQ_IDLE;
        end else begin
          tmr_dec_c = 1'b1;
        end
      end
      default: begin
        state_nxt = IRQ_IDLE;
      end
    endcase
  end

  assign bus.data_rdy_ack    = ack_q;
  assign bus.cfg_interrupt_n = req_n_q;
  assign bus.irq_cnt         = cnt_q;

endmodule

// File: tb/tb_irq_gen.sv
// tb_irq_gen: directed self-checking bench for irq_gen with a timestamp-based
// reference model compared every cycle, plus literal checks per scenario.
module tb_irq_gen;
  import irq_gen_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  irq_gen_if #(.GAP_W(16)) bus ();

  irq_gen #(.GAP_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an interrupt may be raised on any cycle at or after the
  // time the previous gap ends, if an event is outstanding and enabled.
  longint         cyc       = 0;
  longint         m_idle_at = 0;
  logic           m_pend    = 1'b0;
  logic           m_req     = 1'b0;
  logic           m_ack     = 1'b0;
  logic [31:0]    m_cnt     = '0;
  logic           chk_on    = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    m_ack <= rst ? 1'b0 : bus.data_rdy;
    if (rst) begin
      m_pend    <= 1'b0;
      m_req     <= 1'b0;
      m_idle_at <= 0;
      m_cnt     <= '0;
      chk_on    <= 1'b1;
    end else if (m_req) begin
      if (!bus.cfg_interrupt_rdy_n) begin
        m_cnt     <= m_cnt + 32'd1;
        m_req     <= 1'b0;
        m_idle_at <= cyc + 2 + longint'(bus.irq_gap);
        m_pend    <= bus.data_rdy;
      end else begin
        m_pend    <= m_pend | bus.data_rdy;
      end
    end else begin
      if (cyc >= m_idle_at && m_pend && bus.irq_en && bus.cfg_interrupt_msienable)
        m_req <= 1'b1;
      m_pend <= m_pend | bus.data_rdy;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_ack",   64'(bus.data_rdy_ack),    64'(m_ack));
      check("model_req_n", 64'(bus.cfg_interrupt_n), 64'(!m_req));
      check("model_cnt",   64'(bus.irq_cnt),         64'(m_cnt));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic set_defaults();
    bus.data_rdy                = 1'b0;
    bus.cfg_interrupt_rdy_n     = 1'b1;
    bus.irq_en                  = 1'b1;
    bus.cfg_interrupt_msienable = 1'b1;
    bus.irq_gap                 = 16'd0;
  endtask

  task automatic do_reset();
    set_defaults();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse();
    bus.data_rdy = 1'b1;
    @(negedge clk);
    bus.data_rdy = 1'b0;
  endtask

  task automatic wait_req(input int lim, output int waited);
    waited = 0;
    while (bus.cfg_interrupt_n !== 1'b0 && waited < lim) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= lim) check("req_timeout", 64'(bus.cfg_interrupt_n), 64'd0);
  endtask

  task automatic grant_now();
    bus.cfg_interrupt_rdy_n = 1'b0;
    @(negedge clk);
    bus.cfg_interrupt_rdy_n = 1'b1;
  endtask

  initial begin
    int w;
    int acks;
    int lows;
    int req_k[$];
    logic prev_n;

    set_defaults();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack",   64'(bus.data_rdy_ack),    64'd0);
    check("rst_req_n", 64'(bus.cfg_interrupt_n), 64'd1);
    check("rst_cnt",   64'(bus.irq_cnt),         64'd0);

    // Single event, grant two cycles after request
    do_reset();
    pulse();
    check("t1_ack_t1",   64'(bus.data_rdy_ack),    64'd1);
    check("t1_req_n_t1", 64'(bus.cfg_interrupt_n), 64'd1);
    @(negedge clk);
    check("t1_ack_t2",   64'(bus.data_rdy_ack),    64'd0);
    check("t1_req_n_t2", 64'(bus.cfg_interrupt_n), 64'd0);
    @(negedge clk);
    check("t1_req_n_t3", 64'(bus.cfg_interrupt_n), 64'd0);
    @(negedge clk);
    check("t1_req_n_t4", 64'(bus.cfg_interrupt_n), 64'd0);
    grant_now();
    check("t1_req_n_t5", 64'(bus.cfg_interrupt_n), 64'd1);
    check("t1_cnt",      64'(bus.irq_cnt),         64'd1);

    // Moderation: gap 10, events at 0/5/9, immediate grants
    do_reset();
    bus.irq_gap = 16'd10;
    acks = 0;
    prev_n = 1'b1;
    req_k.delete();
    for (int k = 0; k <= 30; k++) begin
      bus.data_rdy = (k == 0 || k == 5 || k == 9);
      if (bus.data_rdy_ack === 1'b1) acks++;
      if (bus.cfg_interrupt_n === 1'b0 && prev_n === 1'b1) req_k.push_back(k);
      prev_n = bus.cfg_interrupt_n;
      bus.cfg_interrupt_rdy_n = bus.cfg_interrupt_n;
      @(negedge clk);
    end
    bus.data_rdy = 1'b0;
    bus.cfg_interrupt_rdy_n = 1'b1;
    check("t2_acks",   64'(acks),         64'd3);
    check("t2_nreq",   64'(req_k.size()), 64'd2);
    if (req_k.size() == 2) check("t2_spacing", 64'(req_k[1] - req_k[0]), 64'd13);
    check("t2_cnt",    64'(bus.irq_cnt),  64'd2);

    // Polling mode: four events, no request until irq_en rises
    do_reset();
    bus.irq_en = 1'b0;
    acks = 0;
    lows = 0;
    for (int k = 0; k <= 14; k++) begin
      bus.data_rdy = (k % 3 == 0) && (k <= 9);
      if (bus.data_rdy_ack === 1'b1) acks++;
      if (bus.cfg_interrupt_n === 1'b0) lows++;
      @(negedge clk);
    end
    bus.data_rdy = 1'b0;
    check("t3_acks", 64'(acks), 64'd4);
    check("t3_lows", 64'(lows), 64'd0);
    bus.irq_en = 1'b1;
    @(negedge clk);
    check("t3_req_after_en", 64'(bus.cfg_interrupt_n), 64'd0);
    grant_now();
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.cfg_interrupt_n === 1'b0) lows++;
      @(negedge clk);
    end
    check("t3_single_req", 64'(lows),        64'd0);
    check("t3_cnt",        64'(bus.irq_cnt), 64'd1);

    // irq_en dropped during REQ, grant delayed 20 cycles
    do_reset();
    pulse();
    wait_req(10, w);
    bus.irq_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("t4_hold", 64'(bus.cfg_interrupt_n), 64'd0);
      @(negedge clk);
    end
    check("t4_hold_at_grant", 64'(bus.cfg_interrupt_n), 64'd0);
    grant_now();
    check("t4_req_n_after", 64'(bus.cfg_interrupt_n), 64'd1);
    check("t4_cnt",         64'(bus.irq_cnt),         64'd1);
    bus.irq_en = 1'b1;

    // data_rdy coincident with grant, gap 4: second request at r+7
    do_reset();
    bus.irq_gap = 16'd4;
    pulse();
    wait_req(10, w);
    bus.data_rdy = 1'b1;
    bus.cfg_interrupt_rdy_n = 1'b0;
    @(negedge clk);
    bus.data_rdy = 1'b0;
    bus.cfg_interrupt_rdy_n = 1'b1;
    check("t5_ack",   64'(bus.data_rdy_ack), 64'd1);
    check("t5_cnt1",  64'(bus.irq_cnt),      64'd1);
    for (int i = 2; i <= 7; i++) begin
      @(negedge clk);
      check("t5_gap", 64'(bus.cfg_interrupt_n), (i == 7) ? 64'd0 : 64'd1);
    end
    grant_now();
    check("t5_cnt2",  64'(bus.irq_cnt), 64'd2);

    // Reset asserted mid-REQ with a coincident event
    do_reset();
    pulse();
    wait_req(10, w);
    grant_now();
    pulse();
    wait_req(10, w);
    rst = 1'b1;
    bus.data_rdy = 1'b1;
    @(negedge clk);
    check("t6_req_n", 64'(bus.cfg_interrupt_n), 64'd1);
    check("t6_ack",   64'(bus.data_rdy_ack),    64'd0);
    check("t6_cnt",   64'(bus.irq_cnt),         64'd0);
    rst = 1'b0;
    bus.data_rdy = 1'b0;
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.cfg_interrupt_n === 1'b0) lows++;
      @(negedge clk);
    end
    check("t6_no_req", 64'(lows), 64'd0);
    pulse();
    wait_req(5, w);
    check("t6_new_req_lat", 64'(w), 64'd1);
    grant_now();
    check("t6_cnt_new", 64'(bus.irq_cnt), 64'd1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_gen.md
# irq_gen

Consumer end of the collapsed-interrupt handshake: accepts the single-cycle `data_rdy` pulse from the interrupt collapser, acknowledges it, and converts pending events into MSI requests on the Virtex-5 PCIe endpoint configuration interrupt port. It sits between the RX buffer collapser and the endpoint block. Bursts of events merge into one interrupt, and interrupts are rate-limited by a host-programmed minimum gap. Host control is a global interrupt enable for driver polling mode.

## Interface
Parameters:
- `GAP_W`, default 16: width of the moderation gap value and timer.

Ports:
- `clk`  in  1  core clock; all logic is single-clock.
- `rst`  in  1  reset; synchronous, active-high.
- `data_rdy`  in  1  one-cycle event pulse from the collapser. The collapser holds off further pulses until it receives an ack.
- `data_rdy_ack`  out  1  one-cycle acknowledge of `data_rdy`.
- `irq_en`  in  1  host interrupt enable (level); 0 means polling mode.
- `irq_gap`  in  GAP_W  minimum spacing between interrupts, in `clk` cycles; sampled on each grant.
- `cfg_interrupt_msienable`  in  1  MSI enabled by the root complex.
- `cfg_interrupt_n`  out  1  interrupt request to the endpoint; active-low.
- `cfg_interrupt_rdy_n`  in  1  request grant from the endpoint; active-low.
- `irq_cnt`  out  32  count of granted interrupts; wraps modulo 2^32.

## Operation
Ack path (independent of the FSM):
- `data_rdy_ack` is registered and equals `data_rdy` delayed by one cycle.
- Every pulse is acknowledged exactly once, regardless of FSM state, `irq_en`, or `rst` release timing.

Pending flag `pend`:
- Set the cycle after `data_rdy`.
- Cleared on a grant, unless `data_rdy` is high in the same cycle as the grant; then `pend` remains set.
- Multiple events while pending merge into one interrupt.

FSM states:
- IDLE: if `pend && irq_en && cfg_interrupt_msienable`, go to REQ. Otherwise stay; `pend` is retained indefinitely.
- REQ: `cfg_interrupt_n` = 0. It is held until `cfg_interrupt_rdy_n` = 0, even if `irq_en` or msienable drops meanwhile, as the endpoint protocol requires. On grant:
  - clear `pend` (per the rule above);
  - increment `irq_cnt`;
  - load the timer with `irq_gap`;
  - go to GAP.
- GAP: if timer == 0, go to IDLE; else decrement. `data_rdy` is still latched and acked in this state.

Other rules:
- `cfg_interrupt_n` is registered; it is low exactly while the state is REQ.
- Reset values: state IDLE, `pend` 0, timer 0, `data_rdy_ack` 0, `cfg_interrupt_n` 1, `irq_cnt` 0.
- Reset during REQ deasserts `cfg_interrupt_n` on the next edge; the pending event is dropped.

## Timing
- `data_rdy` high at cycle t: `data_rdy_ack` high at t+1 only; `pend` = 1 at t+1.
- If idle, enabled and the gap has expired, `cfg_interrupt_n` goes low at t+2.
- Grant seen at cycle r: `cfg_interrupt_n` high at r+1; state is GAP during r+1 .. r+1+G, where G = `irq_gap` sampled at r.
  - IDLE at r+2+G.
  - Earliest next `cfg_interrupt_n` low is r+3+G.
  - `irq_gap` = 0 gives 3-cycle spacing.
- Grant in the same cycle that `cfg_interrupt_n` first goes low is legal: one REQ cycle.
- `irq_en` rising while `pend` = 1 in IDLE: REQ on the next cycle.

## Structure
- Shared package: FSM state encodings (`IRQ_IDLE`, `IRQ_REQ`, `IRQ_GAP`) and the default gap constant `IRQ_GAP_DEFAULT` = 16'd1000, used by the host register block.
- One natural sub-module, `irq_gap_timer`:
  - load, count down, and zero flag;
  - `GAP_W` wide.
- Ack register, `pend`, FSM and counter stay in `irq_gen`.

## Test plan
- Single event, `irq_en`=1, msienable=1, endpoint grants 2 cycles after request:
  - `data_rdy` at t gives `data_rdy_ack` at t+1;
  - `cfg_interrupt_n` low over t+2..t+4 and high at t+5;
  - `irq_cnt`=1.
- Moderation with `irq_gap`=10, events at t, t+5, t+9 and immediate grants:
  - exactly one additional interrupt follows, no earlier than 13 cycles after the first grant;
  - three acks are issued;
  - `irq_cnt`=2.
- Polling mode, `irq_en`=0, 4 events:
  - 4 acks and no request;
  - raising `irq_en` yields exactly one request one cycle later.
- `irq_en` dropped while in REQ with the grant delayed 20 cycles: the request is held the full 20 cycles and counted.
- `data_rdy` coincident with grant: `pend` stays 1, and a second interrupt follows after the gap.
- `rst` asserted mid-REQ: `cfg_interrupt_n`=1, `data_rdy_ack`=0 and `irq_cnt`=0 after the edge; no request until a new `data_rdy`.
